// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one SPI controller between NUM_REQ requesters:
// loads controller write memory, runs a transaction, reads back POCI words.

module spi_request_arbiter_slot #(
  parameter int GW  = 1,
  parameter int IDX = 0
) (
  input  logic [GW-1:0] pick,
  input  logic [GW-1:0] owner,
  input  logic          ready_en,
  input  logic          rsp_en,
  output logic          ready,
  output logic          rsp
);
  assign ready = ready_en && (pick == GW'(IDX));
  assign rsp   = rsp_en && (owner == GW'(IDX));
endmodule

module spi_request_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int MAX_WORDS      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                             axi_clk,
  input  logic                             axi_resetn,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*16-1:0]            req_len,
  input  logic [NUM_REQ*MAX_WORDS*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic                             rsp_err,
  output logic [MAX_WORDS*32-1:0]          rsp_rdata,
  output logic [31:0]                      ctl_mem_write,
  output logic                             ctl_mem_write_strb,
  output logic                             ctl_mem_write_ptr_reset,
  input  logic [31:0]                      ctl_mem_read,
  output logic                             ctl_mem_read_strb,
  output logic                             ctl_mem_read_ptr_reset,
  output logic [31:0]                      ctl_transaction_len,
  output logic [2:0]                       ctl_loop_mode,
  output logic                             ctl_run,
  input  logic [2:0]                       ctl_status,
  output logic                             busy,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             fault
);
  localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WIX = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int NW  = WIX + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_PTR_RST, S_LOAD, S_RUN,
    S_WAIT_DONE, S_WAIT_IDLE, S_READBACK, S_RESP, S_FAULT
  } state_t;

  state_t                       state_q, state_d;
  logic [GW-1:0]                rr_ptr, pick, cand, grant_q;
  logic                         found, any_req;
  logic [15:0]                  len_q;
  logic [MAX_WORDS-1:0][31:0]   wdata_q, rdata_q;
  logic [NW-1:0]                nwords_q, nwords_c;
  logic [WIX-1:0]               widx;
  logic                         phase, err_q, fault_q, fault_rsp_done;
  logic [31:0]                  tcnt, xlen_q;
  logic                         len_bad, last_word, tmo, ready_en, rsp_en;

  assign any_req   = |req_valid;
  assign len_bad   = (len_q == 16'd0) || ({1'b0, len_q} > 17'(MAX_WORDS*32));
  assign nwords_c  = NW'(({1'b0, len_q} + 17'd31) >> 5);
  assign last_word = ({1'b0, widx} == nwords_q - NW'(1));
  assign tmo       = (tcnt == 32'(TIMEOUT_CYCLES-1));

  // first pending requester at or after the RR pointer, wrapping
  always_comb begin
    pick  = rr_ptr;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = GW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (any_req) state_d = S_CHECK;
      S_CHECK:     state_d = len_bad ? S_RESP : S_PTR_RST;
      S_PTR_RST:   state_d = S_LOAD;
      S_LOAD:      if (phase && last_word) state_d = S_RUN;
      S_RUN:       state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (tmo) state_d = S_FAULT;
                   else if (ctl_status == 3'b111) state_d = S_WAIT_IDLE;
      S_WAIT_IDLE: if (tmo) state_d = S_FAULT;
                   else if (!ctl_status[2]) state_d = S_READBACK;
      S_READBACK:  if (last_word) state_d = S_RESP;
      S_RESP:      state_d = S_IDLE;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rr_ptr         <= '0;
      grant_q        <= '0;
      len_q          <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      nwords_q       <= '0;
      widx           <= '0;
      phase          <= 1'b0;
      tcnt           <= '0;
      err_q          <= 1'b0;
      fault_q        <= 1'b0;
      fault_rsp_done <= 1'b0;
      xlen_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (any_req) begin
          grant_q <= pick;
          rr_ptr  <= (pick == GW'(NUM_REQ-1)) ? '0 : pick + 1'b1;
          len_q   <= req_len[int'(pick)*16 +: 16];
          wdata_q <= req_wdata[int'(pick)*MAX_WORDS*32 +: MAX_WORDS*32];
          xlen_q  <= '0;
        end
        S_CHECK: begin
          nwords_q <= nwords_c;
          widx     <= '0;
          phase    <= 1'b0;
          err_q    <= len_bad;
          if (len_bad) rdata_q <= '0;
          else         xlen_q  <= {16'd0, len_q};
        end
        // phase 0 strobes, phase 1 holds data for the controller's delayed capture
        S_LOAD: begin
          phase <= ~phase;
          if (phase) widx <= last_word ? '0 : widx + 1'b1;
        end
        S_RUN: begin
          tcnt <= '0;
          widx <= '0;
        end
        S_WAIT_DONE, S_WAIT_IDLE: begin
          tcnt <= tcnt + 32'd1;
          if (tmo) begin
            fault_q <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        S_READBACK: begin
          for (int j = 0; j < MAX_WORDS; j++) begin
            if (WIX'(j) == widx)  rdata_q[j] <= ctl_mem_read;
            else if (widx == '0) rdata_q[j] <= '0;
          end
          widx <= widx + 1'b1;
        end
        S_FAULT: fault_rsp_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // ready is combinational in IDLE, so force it low while reset is held
  assign ready_en = axi_resetn && (state_q == S_IDLE) && any_req;
  assign rsp_en   = (state_q == S_RESP) || ((state_q == S_FAULT) && !fault_rsp_done);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    spi_request_arbiter_slot #(.GW(GW), .IDX(g)) u_slot (
      .pick     (pick),
      .owner    (grant_q),
      .ready_en (ready_en),
      .rsp_en   (rsp_en),
      .ready    (req_ready[g]),
      .rsp      (rsp_valid[g])
    );
  end

  assign rsp_err                 = rsp_en && err_q;
  assign rsp_rdata               = rdata_q;
  assign ctl_mem_write           = (state_q == S_LOAD) ? wdata_q[widx] : 32'd0;
  assign ctl_mem_write_strb      = (state_q == S_LOAD) && !phase;
  assign ctl_mem_write_ptr_reset = (state_q == S_PTR_RST);
  assign ctl_mem_read_ptr_reset  = (state_q == S_PTR_RST);
  assign ctl_mem_read_strb       = (state_q == S_READBACK);
  assign ctl_transaction_len     = xlen_q;
  assign ctl_loop_mode           = 3'd0;
  assign ctl_run                 = (state_q == S_RUN);
  assign busy                    = (state_q != S_IDLE);
  assign grant_id                = grant_q;
  assign fault                   = fault_q;

endmodule

// File: doc/spi_request_arbiter.md
Name: spi_request_arbiter

Overview:
- Shares one generic SPI controller instance between NUM_REQ independent requesters, such as register-config engines and monitor pollers.
- Grants requesters in round-robin order.
- For each granted request it loads the controller write memory, sets the transaction length, pulses run and tracks the controller status through completion.
- It then reads back the captured POCI words and returns them to the requester.
- Sits in the AXI clock domain between the requester logic and the controller's memory and run interface.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MAX_WORDS, 4, max 32b words per transaction (1..16)
TIMEOUT_CYCLES, 65535, axi_clk cycles allowed from run until the controller returns to idle

Ports:
axi_clk  in  1  clock
axi_resetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_ready  out  NUM_REQ  request accepted; transfer occurs when valid&ready
req_len  in  NUM_REQ*16  per-requester transaction length in bits
req_wdata  in  NUM_REQ*MAX_WORDS*32  per-requester PICO words; word 0 in the LSBs
rsp_valid  out  NUM_REQ  one-cycle response pulse to the granted requester
rsp_err  out  1  response error flag, valid with rsp_valid
rsp_rdata  out  MAX_WORDS*32  captured POCI words
ctl_mem_write  out  32  controller write-memory data
ctl_mem_write_strb  out  1  controller write strobe
ctl_mem_write_ptr_reset  out  1  controller write-pointer clear
ctl_mem_read  in  32  controller read-memory word at the read pointer
ctl_mem_read_strb  out  1  controller read-pointer advance
ctl_mem_read_ptr_reset  out  1  controller read-pointer clear
ctl_transaction_len  out  32  bits to transfer
ctl_loop_mode  out  3  tied to 0
ctl_run  out  1  one-cycle run strobe
ctl_status  in  3  controller status: {triggered, state[1:0]}; state DONE = 2'd3
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
fault  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - All outputs 0, including rsp_rdata and ctl_transaction_len.
  - Round-robin pointer = 0.
  - State = IDLE.
  - Reset mid-transaction aborts immediately; no response is issued.
- IDLE:
  - If any req_valid is set, grant the first requester at or after the RR pointer, wrapping.
  - Assert req_ready[g] for that one cycle.
  - Latch req_len[g] and req_wdata[g].
  - Set RR pointer = (g+1) mod NUM_REQ.
  - Next state CHECK.
- CHECK:
  - nwords = ceil(len/32).
  - If len==0 or len>MAX_WORDS*32: next RESP with err=1; no controller activity.
  - Otherwise next PTR_RST.
- PTR_RST (1 cycle):
  - Assert ctl_mem_write_ptr_reset and ctl_mem_read_ptr_reset.
  - Drive ctl_transaction_len = len; hold it until the next grant.
- LOAD (2 cycles per word, k = 0..nwords-1):
  - Cycle A: ctl_mem_write_strb=1, ctl_mem_write=word k.
  - Cycle B: strb=0, ctl_mem_write still equals word k. The controller captures data one cycle after the strobe.
  - After the last word, go to RUN.
- RUN (1 cycle): ctl_run=1.
- WAIT_DONE: wait for ctl_status==3'b111.
- WAIT_IDLE: wait for ctl_status[2]==0; then go to READBACK.
- Timeout:
  - The timeout counter resets in RUN and increments every cycle in WAIT_DONE and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES sets fault=1 and moves to FAULT.
- READBACK (1 cycle per word):
  - Set ctl_mem_read_strb=1.
  - In the same cycle, capture ctl_mem_read into rsp_rdata word k.
  - Unread words are zeroed.
  - After nwords cycles, go to RESP with err=0.
- RESP (1 cycle):
  - rsp_valid[g]=1 with rsp_err.
  - rsp_rdata stays stable until the next RESP.
  - Next IDLE.
- FAULT:
  - Terminal until reset; no further grants.
  - On entry, issue rsp_valid[g] with err=1 for one cycle.
- Simultaneous events:
  - req_valid from non-granted requesters is ignored until IDLE.
  - A request arriving during RESP is considered in the following IDLE cycle.
- Minimum latency for nwords=n, excluding controller time: grant to run = 2+2n+1 cycles.

Test Plan:
- Req0 len=40, words {A5A5A5A5, 0000003C}, controller model loops PICO to POCI -> 2 strobes, ctl_transaction_len=40, one ctl_run, rsp_valid[0] with rsp_rdata low words {A5A5A5A5, 0000003C}, err=0.
- Req0 and req1 valid in the same cycle, twice in succession -> grant order 0, 1, 0, 1; grant_id matches each time.
- Req1 len=0, then len=MAX_WORDS*32+1 -> rsp_err=1 each time; no ctl_run and no ctl_mem_write_strb pulses.
- ctl_status held at 3'b100 after run, TIMEOUT_CYCLES=100 -> fault=1 at cycle 100; one err response; later req_valid gets no req_ready.
- Assert axi_resetn low during LOAD word 1 -> all outputs 0 in the same cycle; after release, a new len=32 request completes normally.
- len=32*MAX_WORDS -> MAX_WORDS LOAD pairs and MAX_WORDS read strobes; full rsp_rdata populated.
